mpsoc_or1k_termination_monitor: RTL and testbench

// Parametrised run-control monitor for multi-tile OR1K MPSoC systems. It tracks per-core

---
 rtl/mpsoc_or1k_termination_monitor.sv | 114 +++++++++++
 tb/tb_mpsoc_or1k_termination_monitor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_or1k_termination_monitor.sv
// Run-control monitor for a multi-tile OR1K MPSoC: sticky per-core termination tracking,
// run-cycle counting with optional timeout, and per-core stall detection.
module mpsoc_or1k_termination_monitor #(
  parameter int NUM_TILES      = 16,
  parameter int CORES_PER_TILE = 1,
  parameter int CNT_W          = 32,
  parameter int STALL_LIMIT    = 1024,
  localparam int N    = NUM_TILES * CORES_PER_TILE,
  localparam int NT_W = $clog2(N + 1),
  localparam int SC_W = $clog2(STALL_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] timeout_cycles_i,
  input  logic [N-1:0]     termination_i,
  input  logic [N-1:0]     trace_valid_i,
  output logic [1:0]       state_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [N-1:0]     terminated_mask_o,
  output logic [NT_W-1:0]  num_terminated_o,
  output logic [N-1:0]     stalled_mask_o,
  output logic [CNT_W-1:0] cycle_count_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  state_t           state;
  logic [N-1:0]     mask;
  logic [CNT_W-1:0] cycle_count;
  logic [SC_W-1:0]  stall_cnt [N];

  logic [N-1:0] mask_next;
  logic         all_term;
  logic         timeout_hit;

  assign mask_next = mask | termination_i;
  assign all_term  = &mask_next;
  // Extra bit keeps cycle_count+1 from wrapping when the counter is saturated.
  assign timeout_hit = (timeout_cycles_i != '0) &&
                       (({1'b0, cycle_count} + 1'b1) >= {1'b0, timeout_cycles_i});

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mask        <= '0;
      cycle_count <= '0;
    end else if (clear_i) begin
      state       <= IDLE;
      mask        <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state       <= RUN;
            mask        <= '0;
            cycle_count <= '0;
          end
        end
        RUN: begin
          mask <= mask_next;
          if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
          if (all_term)         state <= DONE;
          else if (timeout_hit) state <= TIMEOUT;
        end
        default: ;  // DONE and TIMEOUT hold everything until clear_i
      endcase
    end
  end

  // NOTE: the stall counters are a small array of flops, not a RAM, so resetting every
  // element is cheap and keeps the stalled flags defined straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) stall_cnt[k] <= '0;
    end else if (clear_i || state == IDLE) begin
      for (int k = 0; k < N; k++) stall_cnt[k] <= '0;
    end else if (state == RUN) begin
      for (int k = 0; k < N; k++) begin
        if (trace_valid_i[k] || mask_next[k])
          stall_cnt[k] <= '0;
        else if (stall_cnt[k] != SC_W'(STALL_LIMIT))
          stall_cnt[k] <= stall_cnt[k] + 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default before the loop, so no latch forms.
  always_comb begin
    num_terminated_o = '0;
    stalled_mask_o   = '0;
    for (int k = 0; k < N; k++) begin
      num_terminated_o  = num_terminated_o + NT_W'(mask[k]);
      stalled_mask_o[k] = (stall_cnt[k] == SC_W'(STALL_LIMIT)) && !mask[k];
    end
  end

  assign state_o           = state;
  assign done_o            = (state == DONE);
  assign timeout_o         = (state == TIMEOUT);
  assign terminated_mask_o = mask;
  assign cycle_count_o     = cycle_count;

endmodule

// File: tb/tb_mpsoc_or1k_termination_monitor.sv
// Directed bench for the termination monitor with four cores and an 8-cycle stall limit.
module tb_mpsoc_or1k_termination_monitor;

  localparam int N     = 4;
  localparam int CNT_W = 16;
  localparam int NT_W  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_i;
  logic             clear_i;
  logic [CNT_W-1:0] timeout_cycles_i;
  logic [N-1:0]     termination_i;
  logic [N-1:0]     trace_valid_i;
  logic [1:0]       state_o;
  logic             done_o;
  logic             timeout_o;
  logic [N-1:0]     terminated_mask_o;
  logic [NT_W-1:0]  num_terminated_o;
  logic [N-1:0]     stalled_mask_o;
  logic [CNT_W-1:0] cycle_count_o;

  int tests_run = 0;
  int tests_failed = 0;

  mpsoc_or1k_termination_monitor #(
    .NUM_TILES(4), .CORES_PER_TILE(1), .CNT_W(CNT_W), .STALL_LIMIT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .clear_i(clear_i),
    .timeout_cycles_i(timeout_cycles_i), .termination_i(termination_i),
    .trace_valid_i(trace_valid_i), .state_o(state_o), .done_o(done_o),
    .timeout_o(timeout_o), .terminated_mask_o(terminated_mask_o),
    .num_terminated_o(num_terminated_o), .stalled_mask_o(stalled_mask_o),
    .cycle_count_o(cycle_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] limit);
    timeout_cycles_i = limit;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; clear_i = 1'b0;
    timeout_cycles_i = '0; termination_i = '0; trace_valid_i = '0;
    #12;
    check("rst_state", state_o, 0);
    check("rst_mask", terminated_mask_o, 0);
    check("rst_count", cycle_count_o, 0);
    check("rst_flags", {done_o, timeout_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Terminations are ignored while idle.
    termination_i = 4'b1111;
    tick();
    check("idle_mask", terminated_mask_o, 0);
    check("idle_state", state_o, 0);
    termination_i = '0;

    // Pulses on RUN cycles 3, 5, 9 complete the set.
    trace_valid_i = 4'b1111;
    do_start(0);
    check("run_entry_state", state_o, 1);
    check("run_entry_count", cycle_count_o, 0);
    for (int i = 0; i < 10; i++) begin
      termination_i = (i == 3) ? 4'b0001 : (i == 5) ? 4'b0100 : (i == 9) ? 4'b1010 : 4'b0000;
      tick();
      if (i == 5) check("partial_mask", terminated_mask_o, 4'b0101);
      if (i == 8) check("not_done_yet", state_o, 1);
    end
    termination_i = '0;
    check("done_state", state_o, 2);
    check("done_flag", done_o, 1);
    check("done_mask", terminated_mask_o, 4'b1111);
    check("done_num", num_terminated_o, 4);
    check("done_count", cycle_count_o, 10);
    start_i = 1'b1;
    tick(); tick();
    check("done_hold_state", state_o, 2);
    check("done_frozen_count", cycle_count_o, 10);

    // clear and start together: clear wins.
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0; start_i = 1'b0;
    check("clear_wins_state", state_o, 0);
    check("clear_mask", terminated_mask_o, 0);
    check("clear_count", cycle_count_o, 0);

    // Timeout at 20 with only core0 terminated.
    do_start(20);
    for (int i = 0; i < 20; i++) begin
      termination_i = (i == 0) ? 4'b0001 : 4'b0000;
      tick();
      if (i == 18) check("pre_timeout_state", state_o, 1);
    end
    termination_i = '0;
    check("timeout_state", state_o, 3);
    check("timeout_flags", {done_o, timeout_o}, 2'b01);
    check("timeout_count", cycle_count_o, 20);
    check("timeout_mask", terminated_mask_o, 4'b0001);
    check("timeout_num", num_terminated_o, 1);
    do_clear();

    // Last termination on the timeout cycle: DONE wins.
    do_start(20);
    for (int i = 0; i < 20; i++) begin
      termination_i = (i == 0) ? 4'b0111 : (i == 19) ? 4'b1000 : 4'b0000;
      tick();
    end
    termination_i = '0;
    check("tie_state", state_o, 2);
    check("tie_flags", {done_o, timeout_o}, 2'b10);
    check("tie_count", cycle_count_o, 20);
    do_clear();

    // Stall detection on core2.
    trace_valid_i = 4'b1011;
    do_start(0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 6) check("stall_before_limit", stalled_mask_o, 0);
    end
    check("stall_set", stalled_mask_o, 4'b0100);
    trace_valid_i = 4'b1111;
    tick();
    check("stall_cleared", stalled_mask_o, 0);
    trace_valid_i = 4'b1011;
    for (int i = 0; i < 8; i++) tick();
    check("stall_again", stalled_mask_o, 4'b0100);
    termination_i = 4'b0100;
    tick();
    termination_i = '0;
    check("stall_terminated", stalled_mask_o, 0);
    for (int i = 0; i < 10; i++) tick();
    check("stall_terminated_hold", stalled_mask_o, 0);
    check("stall_mask", terminated_mask_o, 4'b0100);
    do_clear();

    // No timeout: stays in RUN for 5000 cycles.
    trace_valid_i = 4'b1111;
    do_start(0);
    for (int i = 0; i < 5000; i++) tick();
    check("long_run_state", state_o, 1);
    check("long_run_count", cycle_count_o, 5000);

    // Async reset mid-RUN with mask 0011.
    termination_i = 4'b0011;
    tick();
    termination_i = '0;
    check("pre_reset_mask", terminated_mask_o, 4'b0011);
    #2 rst_n = 1'b0;
    #1;
    check("async_state", state_o, 0);
    check("async_mask", terminated_mask_o, 0);
    check("async_num", num_terminated_o, 0);
    check("async_count", cycle_count_o, 0);
    check("async_flags", {done_o, timeout_o, stalled_mask_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
